ro_scan_sequencer: RTL and testbench

Measurement sequencer for the ring-oscillator frequency display path. Steps through `N_CH` ring oscillators: enables one, clears and gates the external edge counter for a fixed window, then captures the count. It saturates the result to the 4-digit display range and presents it as the 16-bit `value` consumed by the display interface, holding each reading for a dwell period before moving to the next channel.

---
 rtl/ro_scan_sequencer.sv | 151 +++++++++++++++
 tb/tb_ro_scan_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ro_scan_sequencer.sv
// Ring-oscillator scan sequencer: enables each oscillator in turn, gates the external
// edge counter for a fixed window, and presents the saturated count to the display.
module ro_scan_sequencer #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned GATE_CYCLES   = 50000000,
  parameter int unsigned SYNC_LAT      = 2,
  parameter int unsigned HOLD_CYCLES   = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] ro_count,
  output logic [1:0]  ro_sel,
  output logic        ro_en,
  output logic        cnt_clr,
  output logic        cnt_en,
  output logic [15:0] value,
  output logic [1:0]  ch_idx,
  output logic        valid,
  output logic        ovf
);

  localparam int unsigned MAX_SG  = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int unsigned MAX_SH  = (SYNC_LAT > HOLD_CYCLES) ? SYNC_LAT : HOLD_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_SG > MAX_SH) ? MAX_SG : MAX_SH;
  // Timer only ever holds (length - 1), so clog2 of the longest length is enough.
  localparam int unsigned TW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LOAD   = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LOAD   = TW'(SYNC_LAT - 1);
  localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);

  localparam logic [15:0] DISP_MAX = 16'd9999;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] GATE   = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] LATCH  = 3'd4;
  localparam logic [2:0] HOLD   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    sel_d, sel_next;
  logic          ro_en_d, cnt_clr_d, cnt_en_d, latch;

  assign sel_next = (ro_sel == 2'(N_CH - 1)) ? 2'd0 : ro_sel + 2'd1;

  // Strobes are computed for the state being entered so the registered outputs
  // line up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    sel_d     = ro_sel;
    ro_en_d   = 1'b0;
    cnt_clr_d = 1'b0;
    cnt_en_d  = 1'b0;
    latch     = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d   = SETTLE;
          timer_d   = SETTLE_LOAD;
          ro_en_d   = 1'b1;
          cnt_clr_d = 1'b1;
        end
      end
      SETTLE: begin
        ro_en_d = 1'b1;
        if (timer_q == '0) begin
          state_d  = GATE;
          timer_d  = GATE_LOAD;
          cnt_en_d = 1'b1;
        end else begin
          timer_d   = timer_q - TW'(1);
          cnt_clr_d = 1'b1;
        end
      end
      GATE: begin
        ro_en_d = 1'b1;
        if (timer_q == '0) begin
          state_d = WAIT;
          timer_d = WAIT_LOAD;
        end else begin
          timer_d  = timer_q - TW'(1);
          cnt_en_d = 1'b1;
        end
      end
      WAIT: begin
        if (timer_q == '0) begin
          state_d = LATCH;
        end else begin
          timer_d = timer_q - TW'(1);
          ro_en_d = 1'b1;
        end
      end
      LATCH: begin
        latch   = 1'b1;
        state_d = HOLD;
        timer_d = HOLD_LOAD;
      end
      HOLD: begin
        if (timer_q == '0) begin
          sel_d = sel_next;
          if (run) begin
            state_d   = SETTLE;
            timer_d   = SETTLE_LOAD;
            ro_en_d   = 1'b1;
            cnt_clr_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      ro_sel  <= 2'd0;
      ro_en   <= 1'b0;
      cnt_clr <= 1'b0;
      cnt_en  <= 1'b0;
      value   <= 16'd0;
      ch_idx  <= 2'd0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ro_sel  <= sel_d;
      ro_en   <= ro_en_d;
      cnt_clr <= cnt_clr_d;
      cnt_en  <= cnt_en_d;
      valid   <= latch;
      if (latch) begin
        value  <= (ro_count > DISP_MAX) ? DISP_MAX : ro_count;
        ovf    <= (ro_count > DISP_MAX);
        ch_idx <= ro_sel;
      end
    end
  end

endmodule

// File: tb/tb_ro_scan_sequencer.sv
// Randomized self-checking bench for ro_scan_sequencer against a cycle-count reference model.
module tb_ro_scan_sequencer;

  localparam int N_CH   = 4;
  localparam int SETTLE = 4;
  localparam int GATE   = 10;
  localparam int SYNC   = 2;
  localparam int HOLD   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] ro_count;
  logic [1:0]  ro_sel;
  logic        ro_en, cnt_clr, cnt_en;
  logic [15:0] value;
  logic [1:0]  ch_idx;
  logic        valid, ovf;

  logic [15:0] chan_cnt [N_CH];
  int          errors = 0;
  int          checks = 0;
  int          ch;

  always #5 clk = ~clk;

  // External per-channel counter: returns whatever count the bench assigned to that oscillator.
  assign ro_count = chan_cnt[ro_sel];

  ro_scan_sequencer #(
    .N_CH          (N_CH),
    .SETTLE_CYCLES (SETTLE),
    .GATE_CYCLES   (GATE),
    .SYNC_LAT      (SYNC),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .ro_count (ro_count),
    .ro_sel   (ro_sel),
    .ro_en    (ro_en),
    .cnt_clr  (cnt_clr),
    .cnt_en   (cnt_en),
    .value    (value),
    .ch_idx   (ch_idx),
    .valid    (valid),
    .ovf      (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] c);
    return (c > 16'd9999) ? 16'd9999 : c;
  endfunction

  // Exclusivity: clear and gate never overlap, gate only with oscillator on, and
  // a reading is never published while an oscillator is running.
  always @(negedge clk) begin
    if (!reset) check("exclusive", {29'd0, cnt_clr & cnt_en, cnt_en & ~ro_en, valid & ro_en}, 0);
  end

  // Called on the first cycle SETTLE is visible; returns on the next SETTLE (cont=1)
  // or a few cycles into IDLE (cont=0).
  task automatic measure(input int c_ch, input bit cont, input bit drop);
    int n, m, k;
    logic [15:0] c;
    c = chan_cnt[c_ch];
    check("sel", 32'(ro_sel), c_ch);
    check("settle_strobes", {29'd0, ro_en, cnt_clr, cnt_en}, 3'b110);
    n = 0;
    while (cnt_clr && n < 50) begin n++; @(negedge clk); end
    check("clr_len", n, SETTLE);
    m = 0;
    while (cnt_en && m < 50) begin
      m++;
      if (drop && m == 5) run = 1'b0;
      @(negedge clk);
    end
    check("gate_len", m, GATE);
    k = 0;
    while (!valid && k < 50) begin k++; @(negedge clk); end
    check("latency", n + m + k, SETTLE + GATE + SYNC + 1);
    check("value", 32'(value), 32'(sat(c)));
    check("ovf", 32'(ovf), 32'(c > 16'd9999));
    check("ch_idx", 32'(ch_idx), c_ch);
    @(negedge clk);
    check("valid_pulse", 32'(valid), 0);
    k = 1;
    while (!ro_en && k < HOLD + 4) begin k++; @(negedge clk); end
    if (cont) begin
      check("hold_len", k, HOLD);
    end else begin
      check("stay_idle", 32'(ro_en), 0);
      check("next_sel", 32'(ro_sel), (c_ch + 1) % N_CH);
      check("retain", 32'(value), 32'(sat(c)));
      check("no_valid", 32'(valid), 0);
    end
  endtask

  initial begin
    int k;
    reset = 1'b1;
    run   = 1'b0;
    for (int i = 0; i < N_CH; i++) chan_cnt[i] = 16'd0;
    #1;
    check("rst_strobes", {28'd0, ro_en, cnt_clr, cnt_en, valid}, 0);
    check("rst_value", {16'd0, value}, 0);
    check("rst_sel", {28'd0, ro_sel, ch_idx}, 0);
    check("rst_ovf", 32'(ovf), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_quiet", {29'd0, ro_en, cnt_clr, cnt_en}, 0);

    // Reset, start and scan order.
    chan_cnt[0] = 16'd1234;
    chan_cnt[1] = 16'd42;
    chan_cnt[2] = 16'($urandom_range(0, 9999));
    chan_cnt[3] = 16'($urandom_range(10000, 65535));
    run = 1'b1;
    @(negedge clk);
    check("start", 32'(ro_en), 1);
    ch = 0;
    for (int i = 0; i < 5; i++) begin
      measure(ch, 1'b1, 1'b0);
      ch = (ch + 1) % N_CH;
    end

    // Saturation boundaries on channels 1..3.
    chan_cnt[1] = 16'd9999;
    chan_cnt[2] = 16'd10000;
    chan_cnt[3] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      measure(ch, 1'b1, 1'b0);
      ch = (ch + 1) % N_CH;
    end

    // Random counts around the display range.
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0:       chan_cnt[ch] = 16'($urandom_range(0, 9999));
        1:       chan_cnt[ch] = 16'($urandom_range(9990, 10010));
        default: chan_cnt[ch] = 16'($urandom);
      endcase
      measure(ch, 1'b1, 1'b0);
      ch = (ch + 1) % N_CH;
    end

    // Stop mid-gate, then resume on the next channel.
    chan_cnt[ch] = 16'($urandom_range(0, 20000));
    measure(ch, 1'b0, 1'b1);
    ch = (ch + 1) % N_CH;
    chan_cnt[ch] = 16'($urandom_range(0, 20000));
    run = 1'b1;
    @(negedge clk);
    check("restart", 32'(ro_en), 1);
    measure(ch, 1'b1, 1'b0);
    ch = (ch + 1) % N_CH;

    // Reset mid-gate: everything clears asynchronously, scan restarts on channel 0.
    k = 0;
    while (!cnt_en && k < 20) begin k++; @(negedge clk); end
    check("reach_gate", 32'(cnt_en), 1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_strobes", {28'd0, ro_en, cnt_clr, cnt_en, valid}, 0);
    check("arst_value", {16'd0, value}, 0);
    check("arst_sel", 32'(ro_sel), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chan_cnt[0] = 16'($urandom_range(0, 20000));
    k = 0;
    while (!ro_en && k < 20) begin k++; @(negedge clk); end
    check("rst_restart", k, 1);
    measure(0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
